// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage Tronsister pipeline: load-use
// interlock, taken-branch flush, MEM-wait freeze with watchdog, perf counters.
module hazard_stall_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  regfile_addr1_ID,
  input  logic [4:0]  regfile_addr2_ID,
  input  logic        reg_read1_ID,
  input  logic        reg_read2_ID,
  input  logic [4:0]  reg_addr_EX,
  input  logic        reg_write_EX,
  input  logic        MemtoReg_EX,
  input  logic        branch_taken_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ready,
  input  logic        clr_counters,
  output logic        stall_PC,
  output logic        stall_IFID,
  output logic        stall_IDEX,
  output logic        stall_EXMEM,
  output logic        flush_IFID,
  output logic        bubble_IDEX,
  output logic        bubble_MEMWB,
  output logic [1:0]  hazard_state,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_e;

  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic load_use;
  logic mem_stall;
  logic freeze;

  // Register 0 is deliberately not excluded so this matches the forwarding unit.
  assign load_use = reg_write_EX & MemtoReg_EX &
                    ((reg_read1_ID & (regfile_addr1_ID == reg_addr_EX)) |
                     (reg_read2_ID & (regfile_addr2_ID == reg_addr_EX)));
  assign mem_stall = mem_req_MEM & ~mem_ready;
  assign freeze    = (state_q == ST_ERROR) | mem_stall;

  // NOTE: every output gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    stall_PC     = 1'b0;
    stall_IFID   = 1'b0;
    stall_IDEX   = 1'b0;
    stall_EXMEM  = 1'b0;
    flush_IFID   = 1'b0;
    bubble_IDEX  = 1'b0;
    bubble_MEMWB = 1'b0;
    if (freeze) begin
      stall_PC     = 1'b1;
      stall_IFID   = 1'b1;
      stall_IDEX   = 1'b1;
      stall_EXMEM  = 1'b1;
      bubble_MEMWB = 1'b1;
    end else if (branch_taken_EX) begin
      // The ID instruction is squashed, so any load-use on it is moot.
      flush_IFID  = 1'b1;
      bubble_IDEX = 1'b1;
    end else if (load_use) begin
      stall_PC    = 1'b1;
      stall_IFID  = 1'b1;
      bubble_IDEX = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q != ST_ERROR) begin
      if (mem_stall) begin
        if (wait_cnt_q == WAIT_LIMIT) begin
          state_d       = ST_ERROR;
          mem_timeout_d = 1'b1;
        end else begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end else begin
        state_d    = ST_RUN;
        wait_cnt_d = 16'd0;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (clr_counters) begin
      stall_cycles_d = 16'd0;
      flush_count_d  = 16'd0;
    end else begin
      if (stall_PC && stall_cycles_q != CNT_MAX) stall_cycles_d = stall_cycles_q + 16'd1;
      if (flush_IFID && flush_count_q != CNT_MAX) flush_count_d = flush_count_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= 16'd0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign hazard_state = state_q;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a driver pushes expected responses
// from a behavioural model, a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;

  localparam int T_OUT = 4;

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic       r1;
    logic       r2;
    logic [4:0] aex;
    logic       wr;
    logic       m2r;
    logic       br;
    logic       req;
    logic       rdy;
    logic       clr;
  } stim_t;

  // ctrl = {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, bubble_IDEX, bubble_MEMWB}
  typedef struct packed {
    logic [6:0]  ctrl;
    logic [1:0]  st;
    logic        to;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  regfile_addr1_ID, regfile_addr2_ID, reg_addr_EX;
  logic        reg_read1_ID, reg_read2_ID, reg_write_EX, MemtoReg_EX;
  logic        branch_taken_EX, mem_req_MEM, mem_ready, clr_counters;
  logic        stall_PC, stall_IFID, stall_IDEX, stall_EXMEM;
  logic        flush_IFID, bubble_IDEX, bubble_MEMWB;
  logic [1:0]  hazard_state;
  logic        mem_timeout;
  logic [15:0] stall_cycles, flush_count;

  hazard_stall_ctrl #(.TIMEOUT_CYCLES(T_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .regfile_addr1_ID(regfile_addr1_ID), .regfile_addr2_ID(regfile_addr2_ID),
    .reg_read1_ID(reg_read1_ID), .reg_read2_ID(reg_read2_ID),
    .reg_addr_EX(reg_addr_EX), .reg_write_EX(reg_write_EX), .MemtoReg_EX(MemtoReg_EX),
    .branch_taken_EX(branch_taken_EX), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .clr_counters(clr_counters),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID), .stall_IDEX(stall_IDEX),
    .stall_EXMEM(stall_EXMEM), .flush_IFID(flush_IFID), .bubble_IDEX(bubble_IDEX),
    .bubble_MEMWB(bubble_MEMWB), .hazard_state(hazard_state), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Reference model: consecutive wait count, error flag, plain integer counters.
  int m_waits, m_stalls, m_flushes;
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    return '0;
  endfunction

  function automatic stim_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic r1,
                               input logic r2, input logic [4:0] aex, input logic wr,
                               input logic m2r, input logic br, input logic req,
                               input logic rdy, input logic clr);
    stim_t s;
    s = '{a1: a1, a2: a2, r1: r1, r2: r2, aex: aex, wr: wr, m2r: m2r,
          br: br, req: req, rdy: rdy, clr: clr};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    regfile_addr1_ID = s.a1;  regfile_addr2_ID = s.a2;
    reg_read1_ID     = s.r1;  reg_read2_ID     = s.r2;
    reg_addr_EX      = s.aex; reg_write_EX     = s.wr;
    MemtoReg_EX      = s.m2r; branch_taken_EX  = s.br;
    mem_req_MEM      = s.req; mem_ready        = s.rdy;
    clr_counters     = s.clr;
  endtask

  task automatic model_reset();
    m_waits = 0; m_stalls = 0; m_flushes = 0; m_err = 0;
  endtask

  // One clock cycle of stimulus: predict this cycle's outputs, then advance the model.
  task automatic drive(input stim_t s);
    exp_t e;
    bit   lu, frz, waiting;
    @(posedge clk); #1;
    apply(s);
    lu      = s.wr && s.m2r && ((s.r1 && s.a1 == s.aex) || (s.r2 && s.a2 == s.aex));
    waiting = s.req && !s.rdy;
    frz     = m_err || waiting;
    if (frz)       e.ctrl = 7'b1111_001;
    else if (s.br) e.ctrl = 7'b0000_110;
    else if (lu)   e.ctrl = 7'b1100_010;
    else           e.ctrl = 7'b0000_000;
    e.st = m_err ? 2'b10 : (m_waits > 0 ? 2'b01 : 2'b00);
    e.to = m_err;
    e.sc = 16'(m_stalls);
    e.fc = 16'(m_flushes);
    sb_q.push_back(e);
    if (!m_err) begin
      if (waiting) begin
        if (m_waits + 1 >= T_OUT) m_err = 1;
        else m_waits++;
      end else begin
        m_waits = 0;
      end
    end
    if (s.clr) begin
      m_stalls = 0; m_flushes = 0;
    end else begin
      if (e.ctrl[6] && m_stalls < 65535) m_stalls++;
      if (e.ctrl[2] && m_flushes < 65535) m_flushes++;
    end
  endtask

  // Asynchronous reset mid-cycle, with immediate checks while rst_n is low.
  task automatic do_reset();
    @(negedge clk); #2;
    apply(idle());
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(hazard_state), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    check("rst_stall_pc", 32'(stall_PC), 32'd0);
    check("rst_counters", {stall_cycles, flush_count}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ctrl", 32'({stall_PC, stall_IFID, stall_IDEX, stall_EXMEM,
                           flush_IFID, bubble_IDEX, bubble_MEMWB}), 32'(e.ctrl));
        check("hazard_state", 32'(hazard_state), 32'(e.st));
        check("mem_timeout", 32'(mem_timeout), 32'(e.to));
        check("stall_cycles", 32'(stall_cycles), 32'(e.sc));
        check("flush_count", 32'(flush_count), 32'(e.fc));
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    int    guard;
    apply(idle());
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    repeat (2) drive(idle());

    // Load-use on r5 through source 2, then EX holds a bubble
    do_reset();
    drive(mk(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) drive(mk(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Load-use together with a taken branch: branch wins
    do_reset();
    drive(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    repeat (2) drive(idle());

    // Three wait cycles with a pending branch, then the memory answers
    do_reset();
    repeat (3) drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    repeat (2) drive(idle());

    // Watchdog: four consecutive waits, then frozen even after the request drops
    do_reset();
    repeat (T_OUT) drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    repeat (3) drive(mk(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    do_reset();
    repeat (2) drive(idle());

    // Stall counter saturation, then clear while a stall is active
    do_reset();
    s = mk(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (70000) drive(s);
    s.clr = 1'b1;
    drive(s);
    repeat (2) drive(idle());

    // Random episodes; odd episodes make the memory slow enough to hit the watchdog
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        s.a1  = 5'($urandom_range(0, 3));
        s.a2  = 5'($urandom_range(0, 3));
        s.aex = 5'($urandom_range(0, 3));
        s.r1  = 1'($urandom_range(0, 1));
        s.r2  = 1'($urandom_range(0, 1));
        s.wr  = 1'($urandom_range(0, 1));
        s.m2r = 1'($urandom_range(0, 1));
        s.br  = ($urandom_range(0, 3) == 0);
        s.req = 1'($urandom_range(0, 1));
        s.rdy = (ep % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
        s.clr = ($urandom_range(0, 15) == 0);
        drive(s);
      end
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected responses never compared", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage Tronsister CPU. It sits upstream of the data-forwarding logic and covers the hazards that forwarding cannot resolve:
- load-use: stalls IF/ID one cycle and inserts an ID/EX bubble, so the load reaches WB before the consumer reaches EX;
- taken branches resolved in EX: flushes IF/ID and ID/EX;
- multi-cycle MEM accesses: freezes the whole pipeline until the memory responds, with a watchdog on the wait.

It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: maximum consecutive MEM wait cycles before the error state; legal range 1..65535.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- regfile_addr1_ID, regfile_addr2_ID  in  5 each  source register addresses of the instruction in ID.
- reg_read1_ID, reg_read2_ID  in  1 each  the instruction in ID reads source 1 / source 2.
- reg_addr_EX  in  5  destination register of the instruction in EX.
- reg_write_EX, MemtoReg_EX  in  1 each  the instruction in EX writes a register / is a load.
- branch_taken_EX  in  1  the branch in EX resolved taken.
- mem_req_MEM  in  1  the instruction in MEM is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- clr_counters  in  1  synchronous clear of the performance counters.
- stall_PC, stall_IFID, stall_IDEX, stall_EXMEM  out  1 each  hold the named register.
- flush_IFID  out  1  load a NOP into IF/ID.
- bubble_IDEX  out  1  load a NOP into ID/EX; has priority over stall_IDEX.
- bubble_MEMWB  out  1  load a NOP into MEM/WB.
- hazard_state  out  2  00 RUN, 01 MEM_WAIT, 10 ERROR.
- mem_timeout  out  1  sticky error flag; set while in ERROR.
- stall_cycles  out  16  saturating count of cycles with stall_PC=1.
- flush_count  out  16  saturating count of cycles with flush_IFID=1.

## Operation
Combinational terms:
- load_use = reg_write_EX & MemtoReg_EX & ((reg_read1_ID & addr1_ID==reg_addr_EX) | (reg_read2_ID & addr2_ID==reg_addr_EX)). Register 0 is not special-cased, matching the forwarding logic.
- freeze = (state==ERROR) | (mem_req_MEM & ~mem_ready).

Control outputs are Mealy and evaluated in strict priority order:
- freeze: stall_PC, stall_IFID, stall_IDEX, stall_EXMEM and bubble_MEMWB are 1; flush_IFID and bubble_IDEX are 0.
- else branch_taken_EX: flush_IFID=1 and bubble_IDEX=1; all stalls are 0. A load_use in the same cycle is ignored because the ID instruction is squashed.
- else load_use: stall_PC=1, stall_IFID=1, bubble_IDEX=1.
- else all control outputs are 0.

FSM state and wait_cnt (16 bits, internal) update on the clock edge:
- RUN or MEM_WAIT, with mem_req_MEM & ~mem_ready:
  - if wait_cnt == TIMEOUT_CYCLES-1, go to ERROR;
  - otherwise wait_cnt++ and go to MEM_WAIT.
- RUN or MEM_WAIT, otherwise: go to RUN and set wait_cnt=0. This includes mem_req_MEM dropping during MEM_WAIT.
- ERROR: absorbing; only rst_n leaves it. mem_timeout=1 and the pipeline stays frozen.
- mem_ready in the same cycle as the request means no stall and no state change.

Counters:
- Increment at the edge when their condition held that cycle.
- Saturate at 0xFFFF.
- clr_counters clears both counters and wins over an increment in the same cycle.

## Timing
- Reset values: state RUN, wait_cnt 0, mem_timeout 0, stall_cycles 0, flush_count 0.
- With idle inputs after reset, all control outputs are 0.
- Control outputs have zero latency: they follow the inputs and state in the same cycle.
- hazard_state, mem_timeout and the counters reflect the edge after the cause.
- A load-use stall lasts exactly one cycle. The next cycle EX holds a bubble (reg_write_EX=0), so the hazard does not re-trigger.
- Freeze duration equals the number of cycles mem_ready stays low while mem_req_MEM is high.
- ERROR is entered at the edge ending the TIMEOUT_CYCLES-th consecutive wait cycle.
- rst_n asserted mid-wait or in ERROR: state returns immediately to RUN and mem_timeout clears asynchronously.

## Test plan
- Load-use: EX has load to r5 (reg_write_EX=1, MemtoReg_EX=1); ID reads r5 via addr2 with reg_read2_ID=1 -> one cycle of stall_PC=stall_IFID=bubble_IDEX=1, then 0; stall_cycles=1.
- Load-use and branch_taken_EX in the same cycle -> flush_IFID=1, bubble_IDEX=1, stall_PC=0; flush_count=1, stall_cycles=0.
- mem_req_MEM=1 with mem_ready low for 3 cycles, branch_taken_EX=1 throughout:
  - freeze outputs on for 3 cycles, flush_IFID=0, hazard_state=01 from the second cycle;
  - on mem_ready=1, the flush is taken that cycle;
  - after that edge, state returns to RUN.
- TIMEOUT_CYCLES=4 with mem_ready held low -> hazard_state=10 and mem_timeout=1 after the 4th edge; freeze persists after mem_req_MEM drops.
- rst_n pulsed low in ERROR mid-cycle -> mem_timeout=0 and hazard_state=00 immediately.
- Counter saturation: force 70000 stall cycles -> stall_cycles=0xFFFF; then clr_counters=1 with a stall active -> 0 next edge.
